serial_word_tx: RTL and testbench

Parallel-load, serial-out transmitter that shifts a WIDTH-bit word out MSB-first on a single data line, with a frame strobe. It is the sending end of the bit-serial link whose receiving end samples sdo into a D flip-flop chain on each frame-qualified bit boundary. It sits between the datapath that produces 13-bit results and the serial interconnect.

---
 rtl/serial_word_tx.sv | 121 ++++++++++++
 tb/tb_serial_word_tx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_tx.sv
// ============================================================================
// Module   : serial_word_tx
// Purpose  : Parallel-load, MSB-first serial transmitter with frame strobe,
//            per-bit sample strobe and end-of-word done pulse.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_word_tx #(
    parameter int WIDTH = 13,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             sdo,
    output logic             frame,
    output logic             bit_stb,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] c_BIT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(DIV - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [DIV_W-1:0] r_div_cnt;

    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [CNT_W-1:0] w_bit_cnt_nxt;
    logic [DIV_W-1:0] w_div_cnt_nxt;

    logic             w_sdo_nxt;
    logic             w_frame_nxt;
    logic             w_stb_nxt;
    logic             w_done_nxt;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            sdo       <= 1'b0;
            frame     <= 1'b0;
            bit_stb   <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_div_cnt <= w_div_cnt_nxt;
            sdo       <= w_sdo_nxt;
            frame     <= w_frame_nxt;
            bit_stb   <= w_stb_nxt;
            done      <= w_done_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_div_cnt_nxt = r_div_cnt;
        case (r_state)
            c_IDLE: begin
                if (load_valid) begin
                    w_state_nxt   = c_SHIFT;
                    w_shift_nxt   = data_in;
                    w_bit_cnt_nxt = c_BIT_LAST;
                    w_div_cnt_nxt = '0;
                end
            end
            c_SHIFT: begin
                if (r_div_cnt == c_DIV_LAST) begin
                    if (r_bit_cnt == '0) begin
                        w_state_nxt = c_DONE;
                    end else begin
                        w_shift_nxt   = {r_shift[WIDTH-2:0], 1'b0};
                        w_bit_cnt_nxt = r_bit_cnt - CNT_W'(1);
                        w_div_cnt_nxt = '0;
                    end
                end else begin
                    w_div_cnt_nxt = r_div_cnt + DIV_W'(1);
                end
            end
            c_DONE: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Outputs are registered, so their next values derive from the next state;
    // bit_stb thus lands exactly on the cycle where div_cnt reaches DIV-1.
    always_comb begin
        load_ready  = (r_state == c_IDLE);
        w_frame_nxt = (w_state_nxt == c_SHIFT);
        w_sdo_nxt   = w_frame_nxt & w_shift_nxt[WIDTH-1];
        w_stb_nxt   = w_frame_nxt & (w_div_cnt_nxt == c_DIV_LAST);
        w_done_nxt  = (w_state_nxt == c_DONE);
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_word_tx.sv
// ============================================================================
// Module   : tb_serial_word_tx
// Purpose  : Self-checking bench for serial_word_tx (DIV=4 and DIV=1 builds).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_word_tx;

    logic        clk;
    logic        rst;
    logic [1:0]  lv;
    logic [12:0] din [2];
    wire  [1:0]  ready;
    wire  [1:0]  sdo;
    wire  [1:0]  frame;
    wire  [1:0]  stb;
    wire  [1:0]  done;

    int n_pass  = 0;
    int n_total = 0;

    bit q0[$];
    bit q1[$];

    typedef struct {
        int          u;
        logic [12:0] data;
        logic [12:0] bits;
        bit          keep;
        int          poke;
        bit          nowait;
    } vec_t;

    vec_t tbl [5];

    serial_word_tx #(.WIDTH(13), .DIV(4)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .load_valid (lv[0]),
        .load_ready (ready[0]),
        .data_in    (din[0]),
        .sdo        (sdo[0]),
        .frame      (frame[0]),
        .bit_stb    (stb[0]),
        .done       (done[0])
    );

    serial_word_tx #(.WIDTH(13), .DIV(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .load_valid (lv[1]),
        .load_ready (ready[1]),
        .data_in    (din[1]),
        .sdo        (sdo[1]),
        .frame      (frame[1]),
        .bit_stb    (stb[1]),
        .done       (done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        else
            n_pass++;
    endtask

    // Scoreboards: each bit_stb pops the bit the receiver should sample
    always @(negedge clk) begin
        if (!rst && stb[0]) begin
            if (q0.size() == 0) check("sb4_extra_stb", stb[0], 1'b0);
            else                check("sb4_bit", sdo[0], q0.pop_front());
        end
        if (!rst && stb[1]) begin
            if (q1.size() == 0) check("sb1_extra_stb", stb[1], 1'b0);
            else                check("sb1_bit", sdo[1], q1.pop_front());
        end
    end

    task automatic accept(input int u, input logic [12:0] d, input logic [12:0] bits,
                          output int waited);
        waited = 0;
        lv[u]  = 1'b1;
        din[u] = d;
        while (!ready[u] && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!ready[u]) check("accept_timeout", ready[u], 1'b1);
        @(posedge clk);
        for (int k = 12; k >= 0; k--) begin
            if (u == 0) q0.push_back(bits[k]);
            else        q1.push_back(bits[k]);
        end
    endtask

    task automatic run_window(input int u, input int len, input bit keep, input int poke);
        int f_cnt = 0, f_first = 0, f_last = 0;
        int d_cnt = 0, d_at = 0, r_at = 0, s_cnt = 0, sf_cnt = 0;
        for (int cyc = 1; cyc <= len + 2; cyc++) begin
            @(negedge clk);
            if (cyc == 1 && !keep) lv[u] = 1'b0;
            if (poke != 0 && cyc == poke)     begin lv[u] = 1'b1; din[u] = 13'h1555; end
            if (poke != 0 && cyc == poke + 1) begin lv[u] = 1'b0; din[u] = 13'h0155; end
            if (frame[u]) begin
                f_cnt++;
                if (f_first == 0) f_first = cyc;
                f_last = cyc;
            end
            if (done[u]) begin
                d_cnt++;
                if (d_at == 0) d_at = cyc;
            end
            if (stb[u]) begin
                s_cnt++;
                if (frame[u]) sf_cnt++;
            end
            if (ready[u] && r_at == 0) r_at = cyc;
        end
        check("frame_len",   f_cnt,   len);
        check("frame_first", f_first, 1);
        check("frame_last",  f_last,  len);
        check("done_count",  d_cnt,   1);
        check("done_cycle",  d_at,    len + 1);
        check("ready_cycle", r_at,    len + 2);
        check("stb_count",   s_cnt,   (len == 13) ? 13 : 13);
        check("stb_in_frame", sf_cnt, s_cnt);
    endtask

    initial begin
        int w, dcnt, fcnt;

        tbl[0] = '{0, 13'h1A5B, 13'b1101001011011, 1'b0, 0,  1'b0};
        tbl[1] = '{0, 13'h1FFF, 13'b1111111111111, 1'b1, 0,  1'b0};
        tbl[2] = '{0, 13'h0001, 13'b0000000000001, 1'b0, 0,  1'b1};
        tbl[3] = '{0, 13'h0AAA, 13'b0101010101010, 1'b0, 21, 1'b0};
        tbl[4] = '{1, 13'h1A5B, 13'b1101001011011, 1'b0, 0,  1'b0};

        rst    = 1'b1;
        lv     = 2'b11;
        din[0] = 13'h1234;
        din[1] = 13'h0777;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        lv  = 2'b00;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("rst_sdo",   sdo[u],   1'b0);
            check("rst_frame", frame[u], 1'b0);
            check("rst_done",  done[u],  1'b0);
            check("rst_stb",   stb[u],   1'b0);
            check("rst_ready", ready[u], 1'b1);
        end

        for (int i = 0; i < 5; i++) begin
            accept(tbl[i].u, tbl[i].data, tbl[i].bits, w);
            if (tbl[i].nowait) check("b2b_accept_wait", w, 0);
            run_window(tbl[i].u, (tbl[i].u == 0) ? 52 : 13, tbl[i].keep, tbl[i].poke);
        end

        // Abort during bit 7 (cycles N+29..N+32) with a one-cycle reset
        accept(0, 13'h1A5B, 13'b1101001011011, w);
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (cyc == 1)  lv[0] = 1'b0;
            if (cyc == 30) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        check("abort_frame", frame[0], 1'b0);
        check("abort_sdo",   sdo[0],   1'b0);
        check("abort_stb",   stb[0],   1'b0);
        check("abort_done",  done[0],  1'b0);
        check("abort_ready", ready[0], 1'b1);
        check("abort_bits_left", q0.size(), 6);
        q0.delete();
        dcnt = 0;
        fcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done[0])  dcnt++;
            if (frame[0]) fcnt++;
        end
        check("abort_no_done",  dcnt, 0);
        check("abort_no_frame", fcnt, 0);

        accept(0, 13'h0F0F, 13'b0111100001111, w);
        run_window(0, 52, 1'b0, 0);

        repeat (5) @(negedge clk);
        check("sb4_empty", q0.size(), 0);
        check("sb1_empty", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
